// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing for the binary-to-BCD converter and the display driver.
package bin2bcd_pkg;

  localparam int BCD_W    = 15;
  localparam int BCD_NDIG = 5;
  localparam int CNT_W    = $clog2(BCD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: W shift cycles plus one DONE cycle per conversion.
// Optional macro BCD_LZB_EN adds a registered leading-zero blanking mask (blank_o).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W    = BCD_W,
  parameter int NDIG = BCD_NDIG
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [W-1:0]      bin_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [4*NDIG-1:0] bcd_o
`ifdef BCD_LZB_EN
  ,
  output logic [NDIG-1:0]   blank_o
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam longint unsigned MAX_BIN = (64'd1 << W) - 64'd1;

  generate
    if (pow10(NDIG) <= MAX_BIN) begin : g_ndig_too_small
      $error("bin2bcd_seq: NDIG digits cannot represent a W-bit value");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      sr_q, sr_d;
  logic [4*NDIG-1:0] scr_q, scr_d;
  logic [4*NDIG-1:0] scr_adj;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (scr_adj[4*g +: 4])
    );
  end

`ifdef BCD_LZB_EN
  logic [NDIG-1:0] blank_q, blank_d, blank_calc;
  logic            any_nz;

  // Scanning from the top digit down, a digit is blank until a nonzero digit has been seen.
  always_comb begin
    any_nz     = 1'b0;
    blank_calc = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      any_nz        = any_nz | (scr_q[4*i +: 4] != 4'd0);
      blank_calc[i] = ~any_nz;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef BCD_LZB_EN
      blank_q <= {{(NDIG-1){1'b1}}, 1'b0};
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
`ifdef BCD_LZB_EN
      blank_q <= blank_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
`ifdef BCD_LZB_EN
    blank_d = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sr_d    = bin_i;
          scr_d   = '0;
          cnt_d   = CW'(W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, sr_d} = {scr_adj, sr_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scr_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
`ifdef BCD_LZB_EN
        blank_d = blank_calc;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign bcd_o   = bcd_q;
`ifdef BCD_LZB_EN
  assign blank_o = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference model.
// Also covers the BCD_LZB_EN blanking mask when that macro is defined.
module tb_bin2bcd_seq;

  localparam int W    = 15;
  localparam int NDIG = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [W-1:0]      bin;
  logic              busy;
  logic              valid;
  logic [4*NDIG-1:0] bcd;
`ifdef BCD_LZB_EN
  logic [NDIG-1:0]   blank;
`endif

  int totalCount = 0;
  int badCount   = 0;

  bin2bcd_seq #(.W(W), .NDIG(NDIG)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .bin_i   (bin),
    .busy_o  (busy),
    .valid_o (valid),
    .bcd_o   (bcd)
`ifdef BCD_LZB_EN
    ,
    .blank_o (blank)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4*NDIG-1:0] modelBcd(input int v);
    logic [4*NDIG-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [NDIG-1:0] modelBlank(input int v);
    logic [NDIG-1:0] b;
    int p;
    b = '0;
    p = 10;
    for (int i = 1; i < NDIG; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion: latency, busy length, result, stability of bcd, single valid pulse.
  task automatic applyStimulus(input int value, input string tag);
    logic [4*NDIG-1:0] prevBcd;
    bit held;
    int cycles;
    int busyCycles;
    prevBcd    = bcd;
    held       = 1'b1;
    cycles     = 0;
    busyCycles = 0;
    start = 1'b1;
    bin   = W'(value);
    tick();
    start = 1'b0;
    if (busy) busyCycles++;
    while (!valid && cycles < 40) begin
      tick();
      cycles++;
      if (busy) busyCycles++;
      if (!valid && bcd !== prevBcd) held = 1'b0;
    end
    checkOutput({tag, "_latency"}, cycles, 16);
    checkOutput({tag, "_busy_len"}, busyCycles, 16);
    checkOutput({tag, "_bcd"}, 32'(bcd), 32'(modelBcd(value)));
    checkOutput({tag, "_bcd_held"}, 32'(held), 32'd1);
`ifdef BCD_LZB_EN
    checkOutput({tag, "_blank"}, 32'(blank), 32'(modelBlank(value)));
`endif
    tick();
    checkOutput({tag, "_valid_pulse"}, 32'(valid), 32'd0);
    checkOutput({tag, "_bcd_after"}, 32'(bcd), 32'(modelBcd(value)));
  endtask

  initial begin
    int validCount;
    int c, t1, t2;
    logic [4*NDIG-1:0] got, b1, b2;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_bcd", 32'(bcd), 32'd0);
`ifdef BCD_LZB_EN
    checkOutput("reset_blank", 32'(blank), 32'h1E);
`endif
    rst = 1'b0;
    tick();

    applyStimulus(0, "zero");
    applyStimulus(32767, "max");
    applyStimulus(12345, "v12345");
    applyStimulus(9, "v9");
    applyStimulus(305, "v305");
    applyStimulus(10000, "v10000");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(int'($urandom_range(32767, 0)), $sformatf("rand%0d", i));
    end

    // start pulses while busy must be ignored
    $display("[TB] start-while-busy");
    start = 1'b1;
    bin   = W'(500);
    tick();
    validCount = 0;
    got = '0;
    for (int k = 1; k <= 30; k++) begin
      if (k >= 3 && k <= 10) begin
        start = 1'b1;
        bin   = W'(777);
      end else begin
        start = 1'b0;
      end
      tick();
      if (valid) begin
        validCount++;
        got = bcd;
      end
    end
    checkOutput("ignore_valid_count", validCount, 1);
    checkOutput("ignore_bcd", 32'(got), 32'h00500);

    // start held high: back-to-back conversions
    $display("[TB] back-to-back");
    start = 1'b1;
    bin   = W'(1);
    tick();
    bin = W'(2);
    c  = 0;
    t1 = -1;
    t2 = -1;
    b1 = '0;
    b2 = '0;
    while (t2 < 0 && c < 60) begin
      tick();
      c++;
      if (valid) begin
        if (t1 < 0) begin
          t1 = c;
          b1 = bcd;
        end else begin
          t2 = c;
          b2 = bcd;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b_first_latency", t1, 16);
    checkOutput("b2b_spacing", t2 - t1, 17);
    checkOutput("b2b_bcd1", 32'(b1), 32'h00001);
    checkOutput("b2b_bcd2", 32'(b2), 32'h00002);
    repeat (3) tick();
    checkOutput("b2b_idle_after", 32'(busy), 32'd0);

    // reset in the middle of a conversion
    $display("[TB] mid-conversion reset");
    applyStimulus(4321, "pre_rst");
    start = 1'b1;
    bin   = W'(99);
    tick();
    start = 1'b0;
    validCount = 0;
    repeat (7) begin
      tick();
      if (valid) validCount++;
    end
    rst = 1'b1;
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_bcd", 32'(bcd), 32'd0);
`ifdef BCD_LZB_EN
    checkOutput("rst_blank", 32'(blank), 32'h1E);
`endif
    rst = 1'b0;
    repeat (30) begin
      tick();
      if (valid) validCount++;
    end
    checkOutput("rst_no_valid", validCount, 0);
    checkOutput("rst_bcd_stays", 32'(bcd), 32'd0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
